// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, opcodes for the
// two-word instruction forms, and the fetch-stage state encoding.
package pipeline_pkg;

  localparam int DEF_INST_WIDTH = 16;
  localparam int DEF_PC_WIDTH   = 32;

  localparam logic [4:0] OP_LDM  = 5'b10010;
  localparam logic [4:0] OP_LDD  = 5'b10011;
  localparam logic [4:0] OP_STD  = 5'b10100;
  localparam logic [4:0] OP_IADD = 5'b01100;

  typedef enum logic {
    S_INST = 1'b0,
    S_IMM  = 1'b1
  } fetch_state_t;

  // True when the opcode is followed by a 16-bit immediate word.
  function automatic logic is_two_word(input logic [4:0] opcode);
    return (opcode == OP_LDM) || (opcode == OP_LDD) ||
           (opcode == OP_STD) || (opcode == OP_IADD);
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with load (redirect), increment and hold.
// Increment wraps modulo 2^PC_WIDTH.
module pc_register #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  // Reset beats load beats increment; otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset_n)  pc <= RESET_PC;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_WIDTH'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, assembles one- and two-word
// instructions and presents them through the IF/ID output register.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int                  INST_WIDTH = DEF_INST_WIDTH,
  parameter int                  PC_WIDTH   = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(32)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [INST_WIDTH-1:0] if_instr,
  output logic [INST_WIDTH-1:0] if_imm,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_valid
);

  fetch_state_t          state, state_d;
  logic [PC_WIDTH-1:0]   pc;
  logic [INST_WIDTH-1:0] hold_instr;
  logic [PC_WIDTH-1:0]   hold_pc;

  logic pc_load, pc_inc;
  logic hold_en;      // capture first word of a two-word instruction
  logic out_en;       // load the output register with a complete instruction
  logic out_from_imm; // completing word is an immediate (use held first word)
  logic clr_valid;    // emit a bubble

  logic [4:0] opcode;
  assign opcode    = imem_rdata[15:11];
  assign imem_addr = pc;

  pc_register #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pc_load),
    .load_val (redirect_pc),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_INST;
    else          state <= state_d;
  end

  // Next state and datapath controls; redirect overrides stall.
  always_comb begin
    state_d      = state;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    hold_en      = 1'b0;
    out_en       = 1'b0;
    out_from_imm = 1'b0;
    clr_valid    = 1'b0;
    if (redirect_valid) begin
      pc_load   = 1'b1;
      state_d   = S_INST;
      clr_valid = 1'b1;
    end else if (!stall) begin
      pc_inc = 1'b1;
      case (state)
        S_INST: begin
          if (is_two_word(opcode)) begin
            hold_en   = 1'b1;
            state_d   = S_IMM;
            clr_valid = 1'b1;
          end else begin
            out_en = 1'b1;
          end
        end
        S_IMM: begin
          out_en       = 1'b1;
          out_from_imm = 1'b1;
          state_d      = S_INST;
        end
        default: state_d = S_INST;
      endcase
    end
  end

  // Partial-instruction holding registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (hold_en) begin
      hold_instr <= imem_rdata;
      hold_pc    <= pc;
    end
  end

  // IF/ID output register; data fields keep their value across bubbles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_instr <= '0;
      if_imm   <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (out_en) begin
      if_instr <= out_from_imm ? hold_instr : imem_rdata;
      if_imm   <= out_from_imm ? imem_rdata : '0;
      if_pc    <= out_from_imm ? hold_pc    : pc;
      if_valid <= 1'b1;
    end else if (clr_valid) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, drives the instruction-memory address, and assembles one- and two-word (instruction plus 16-bit immediate) instructions. It presents them through its own IF/ID output register to the decode stage. Branch redirects come from later stages, and a stall comes from the hazard logic.

## Interface
Parameters:
- `INST_WIDTH`, 16: instruction and immediate word width.
- `PC_WIDTH`, 32: program-counter width.
- `RESET_PC`, 32: PC value loaded on reset (`2**5`).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `imem_addr`, output, `PC_WIDTH`: instruction-memory address; combinational, equals `pc`.
- `imem_rdata`, input, `INST_WIDTH`: memory word at `imem_addr`, valid in the same cycle (combinational read).
- `stall`, input, 1: freeze the PC, state and outputs.
- `redirect_valid`, input, 1: taken branch/jump/call/ret; flushes the stage.
- `redirect_pc`, input, `PC_WIDTH`: target of the redirect.
- `if_instr`, output, `INST_WIDTH`: fetched instruction.
- `if_imm`, output, `INST_WIDTH`: immediate word; 0 for one-word instructions.
- `if_pc`, output, `PC_WIDTH`: address of the instruction's first word.
- `if_valid`, output, 1: outputs carry a real instruction; 0 means bubble.

## Operation
- Opcode is `instr[15:11]`. An instruction is two-word when the opcode is LDM (`5'b10010`), LDD (`5'b10011`), STD (`5'b10100`) or IADD (`5'b01100`); every other opcode is one-word.
- State machine: `S_INST` (fetching the first word) and `S_IMM` (fetching the immediate word).
- Registers: `pc`, `state`, `hold_instr`, `hold_pc`, and the output registers.
- Priority each edge: reset, then redirect, then stall, then normal operation.
- Reset (`reset_n`=0 at edge):
  - `pc`=`RESET_PC`, `state`=`S_INST`.
  - `hold_*`=0, `if_instr`=0, `if_imm`=0, `if_pc`=0, `if_valid`=0.
- Redirect:
  - `pc`=`redirect_pc`, `state`=`S_INST`, `if_valid`=0.
  - The held partial instruction is discarded.
  - A redirect overrides a simultaneous stall.
- Stall (no redirect): every register holds; `imem_addr` stays at the same `pc`.
- `S_INST`, one-word opcode:
  - `if_instr`=`imem_rdata`, `if_imm`=0, `if_pc`=`pc`, `if_valid`=1.
  - `pc`=`pc`+1; stay in `S_INST`.
- `S_INST`, two-word opcode:
  - `hold_instr`=`imem_rdata`, `hold_pc`=`pc`.
  - `pc`=`pc`+1, `state`=`S_IMM`, `if_valid`=0.
- `S_IMM`:
  - `if_instr`=`hold_instr`, `if_imm`=`imem_rdata`, `if_pc`=`hold_pc`, `if_valid`=1.
  - `pc`=`pc`+1, `state`=`S_INST`.
- PC arithmetic is modulo 2^`PC_WIDTH`; `pc`+1 at all-ones wraps to 0, including between the two words of one instruction.
- When `if_valid`=0, output data fields keep their previous values, except on reset, which zeroes them.

## Timing
- One-word instruction: address presented in cycle N; output valid after edge N+1. Latency 1, throughput 1 per cycle.
- Two-word instruction: first word in cycle N, immediate in cycle N+1; output valid after edge N+2. Exactly one bubble is inserted.
- Redirect asserted in cycle N: `imem_addr`=`redirect_pc` in cycle N+1. The first valid output from the target appears after edge N+2 (one-word target).
- Stall asserted in cycle N: outputs and `imem_addr` are unchanged during N+1. A stall held k cycles delays everything by exactly k cycles, and no instruction is lost or duplicated.
- Reset mid-`S_IMM`: the partial instruction is dropped, and `if_valid`=0 the cycle after the reset edge.

## Structure
- Shared package `pipeline_pkg`:
  - `INST_WIDTH` and `PC_WIDTH` defaults.
  - Opcode constants for LDM, LDD, STD, IADD.
  - The `is_two_word(opcode)` function, which decode reuses.
  - The fetch-state enum.
- One natural sub-module: `pc_register` (`pc` with load, increment and hold controls).

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles, release → `imem_addr`=32, `if_valid`=0, all outputs 0.
- Sequential: NOT at 32, ADD at 33 → `if_pc`=32 then 33, `if_valid`=1 both cycles, `if_imm`=0.
- Two-word: LDM (`0x9000`) at 32 with `0x1234` at 33 → one bubble, then `if_instr`=`0x9000`, `if_imm`=`0x1234`, `if_pc`=32; next fetch at 34.
- Stall: 3-cycle stall asserted while in `S_IMM` → `imem_addr` holds 33 and outputs hold; LDM then completes with the correct immediate.
- Redirect: `redirect_valid` with target 100 while in `S_IMM` (stall also high) → LDM dropped, `if_valid`=0, next valid `if_pc`=100.
- Wrap: `PC_WIDTH`=6, two-word instruction at 63 → immediate fetched from 0, `if_pc`=63, next fetch at 1.
